// File: rtl/led_blink_pkg.sv
// Shared types and helpers for the LED blink-code scheduler.
package led_blink_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Counter width for values 0..v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/led_blink_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from a rotating priority pointer.
module rr_arbiter
    import led_blink_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NREQ-1:0]              req_i,
    input  logic                         update_i,
    output logic [NREQ-1:0]              gnt_c_o,
    output logic                         valid_c_o,
    output logic [clog2_min1(NREQ)-1:0]  gnt_idx_c_o
);

    localparam int unsigned IDW = clog2_min1(NREQ);

    logic [IDW-1:0] ptr_q, ptr_d;

    // Scan requesters starting at ptr_q, wrapping once around.
    always_comb begin
        int             idx;
        logic [IDW-1:0] sel;
        logic           found;
        gnt_c_o     = '0;
        valid_c_o   = 1'b0;
        gnt_idx_c_o = '0;
        found       = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= int'(NREQ)) begin
                idx = idx - int'(NREQ);
            end
            sel = IDW'(idx);
            if (!found && req_i[sel]) begin
                found        = 1'b1;
                gnt_c_o[sel] = 1'b1;
                gnt_idx_c_o  = sel;
            end
        end
        valid_c_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (update_i && valid_c_o) begin
            if (int'(gnt_idx_c_o) + 1 >= int'(NREQ)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_c_o + IDW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/led_blink_sched.sv
// Shares one LED among requesters: each granted job blinks its code count, then a gap.
module led_blink_sched
    import led_blink_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned CNTW      = 4,
    parameter int unsigned PRESCALE  = 12500000,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 2,
    parameter int unsigned GAP_TICKS = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NREQ-1:0]              req_i,
    input  logic [NREQ*CNTW-1:0]         code_i,
    output logic [NREQ-1:0]              ack_o,
    output logic [clog2_min1(NREQ)-1:0]  gnt_id_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         led_o
);

    localparam int unsigned IDW     = clog2_min1(NREQ);
    localparam int unsigned PW      = clog2_min1(PRESCALE);
    localparam int unsigned MAXT_OF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned MAXT    = (MAXT_OF > GAP_TICKS) ? MAXT_OF : GAP_TICKS;
    localparam int unsigned TW      = clog2_min1(MAXT);

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            led_q, led_d;

    logic [NREQ-1:0] arb_gnt_c;
    logic            arb_valid_c;
    logic [IDW-1:0]  arb_idx_c;
    logic            grant_c;
    logic [CNTW-1:0] code_sel_c;
    logic [TW-1:0]   tick_last_c;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .update_i    (grant_c),
        .gnt_c_o     (arb_gnt_c),
        .valid_c_o   (arb_valid_c),
        .gnt_idx_c_o (arb_idx_c)
    );

    // Blink count of the requester the arbiter currently selects.
    always_comb begin
        code_sel_c = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (arb_gnt_c[k]) begin
                code_sel_c = code_sel_c | code_i[k*CNTW +: CNTW];
            end
        end
    end

    always_comb begin
        case (state_q)
            ST_ON:   tick_last_c = TW'(ON_TICKS - 1);
            ST_OFF:  tick_last_c = TW'(OFF_TICKS - 1);
            default: tick_last_c = TW'(GAP_TICKS - 1);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        tick_d   = tick_q;
        cnt_d    = cnt_q;
        gnt_id_d = gnt_id_q;
        ack_d    = '0;
        done_d   = 1'b0;
        grant_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid_c) begin
                    grant_c  = 1'b1;
                    gnt_id_d = arb_idx_c;
                    ack_d    = arb_gnt_c;
                    cnt_d    = code_sel_c;
                    presc_d  = '0;
                    tick_d   = '0;
                    state_d  = (code_sel_c != '0) ? ST_ON : ST_GAP;
                end
            end
            default: begin
                if (presc_q != PW'(PRESCALE - 1)) begin
                    presc_d = presc_q + PW'(1);
                end else if (tick_q != tick_last_c) begin
                    presc_d = '0;
                    tick_d  = tick_q + TW'(1);
                end else begin
                    // Phase boundary: counters restart for the next phase.
                    presc_d = '0;
                    tick_d  = '0;
                    case (state_q)
                        ST_ON: begin
                            cnt_d   = cnt_q - CNTW'(1);
                            state_d = (cnt_q != CNTW'(1)) ? ST_OFF : ST_GAP;
                        end
                        ST_OFF: state_d = ST_ON;
                        default: begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
        endcase

        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            tick_q   <= '0;
            cnt_q    <= '0;
            gnt_id_q <= '0;
            ack_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            cnt_q    <= cnt_d;
            gnt_id_q <= gnt_id_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
        end
    end

    assign ack_o    = ack_q;
    assign gnt_id_o = gnt_id_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign led_o    = led_q;

endmodule

// File: doc/led_blink_sched.md
LED_BLINK_SCHED -- requirements
Module: led_blink_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters, >=1.
REQ-002 SHALL have parameter CNTW, default 4: blink-code width in bits.
REQ-003 SHALL have parameter PRESCALE, default 12500000: clock cycles per tick, >=1.
REQ-004 SHALL have parameters ON_TICKS, OFF_TICKS and GAP_TICKS, defaults 2, 2 and 8: phase lengths in ticks, each >=1.
REQ-005 SHALL have one clock and an asynchronous, active-low reset. Ports are clk_i and rst_ni.
REQ-006 SHALL have port clk_i  input  1: the single clock; all flops on rising edge.
REQ-007 SHALL have port rst_ni  input  1: asynchronous active-low reset.
REQ-008 SHALL have port req_i  input  NREQ: per-requester blink request, level.
REQ-009 SHALL have port code_i  input  NREQ*CNTW: blink counts; requester k occupies bits [k*CNTW +: CNTW].
REQ-010 SHALL have port ack_o  output  NREQ: one-cycle grant/accept pulse per requester.
REQ-011 SHALL have port gnt_id_o  output  $clog2(NREQ) (min 1): index of the current or last granted requester.
REQ-012 SHALL have port busy_o  output  1: high whenever state != IDLE.
REQ-013 SHALL have port done_o  output  1: one-cycle pulse when a job finishes.
REQ-014 SHALL have port led_o  output  1: LED drive, taken directly from a flop.

Function
REQ-015 SHALL implement the FSM states IDLE, ON, OFF and GAP. led_o=1 only in ON.
REQ-016 SHALL arbitrate in IDLE only: if any req_i is set, the edge grants requester g, picked round-robin starting at pointer ptr. After the grant, ptr <= (g+1) mod NREQ.
REQ-017 SHALL update the following at the grant edge: code latched from code_i[g], gnt_id_o <= g, ack_o[g] <= 1 for exactly one cycle (the first non-IDLE cycle), and prescaler and tick counters cleared.
REQ-018 SHALL go to ON on grant if the latched code is nonzero. If the code is 0, it SHALL go to GAP and led_o SHALL stay 0.
REQ-019 SHALL make the ON, OFF and GAP phases last exactly ON_TICKS*PRESCALE, OFF_TICKS*PRESCALE and GAP_TICKS*PRESCALE cycles.
REQ-020 SHALL decrement the blink count at the end of each ON phase.
REQ-021 At the end of an ON phase, SHALL go to OFF if the remaining count is nonzero, else to GAP.
REQ-022 At the end of an OFF phase, SHALL go to ON.
REQ-023 At the end of GAP, SHALL go to IDLE and raise done_o for the first IDLE cycle.
REQ-024 SHALL make the total job length n*ON + (n-1)*OFF + GAP phases for code n>=1.
REQ-025 SHALL allow a new grant in the same cycle that done_o is high. This gives a minimum of 1 IDLE cycle between jobs.
REQ-026 SHALL ignore req_i and code_i while busy. A req_i dropped before its grant is withdrawn with no effect.
REQ-027 SHALL not wrap any counter: the blink count only decrements from a nonzero value, and the prescaler and tick counters reset at every phase change.
REQ-028 SHALL hold gnt_id_o at its last value while IDLE.

Reset
REQ-029 On rst_ni low, SHALL immediately set state=IDLE, ptr=0, led_o=0, ack_o=0, done_o=0, busy_o=0 and gnt_id_o=0, and clear all counters.
REQ-030 SHALL abort any job in progress on mid-job reset, with no done_o or ack_o.
REQ-031 After reset release, SHALL allow the first grant no earlier than the first rising edge with rst_ni high.

Structure
REQ-032 SHALL place the state enum typedef (IDLE/ON/OFF/GAP) in the shared package led_blink_pkg.
REQ-033 SHALL implement the round-robin grant and the ptr register in sub-module rr_arbiter. rr_arbiter SHALL output a one-hot grant and a valid, and take an update strobe.
REQ-034 SHALL keep the prescaler, tick counter, blink counter and FSM in led_blink_sched.

Verification
All scenarios use PRESCALE=2, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3, NREQ=4, CNTW=4.
REQ-035 SHALL cover a single job: req_i=0001 with code 3 -> ack_o[0] one cycle; led_o high 4, low 2, high 4, low 2, high 4; then GAP 6 cycles low; done_o on cycle 23 after the grant edge.
REQ-036 SHALL cover a zero code: req_i=0100 with code 0 -> ack_o[2] one cycle; led_o stays 0; busy_o 6 cycles; done_o pulse.
REQ-037 SHALL cover round-robin: req_i=1111 held, all codes 1 -> grant order 0,1,2,3,0; each ack_o exactly once per job; done_o and the next ack_o separated by exactly 1 cycle.
REQ-038 SHALL cover a withdrawn request: req_i[1] pulsed for 2 cycles during a busy job, then dropped -> no ack_o[1], and the next grant goes to another active requester.
REQ-039 SHALL cover reset mid-job: rst_ni low during the second ON phase -> led_o=0 and busy_o=0 immediately, no done_o; after release with req_i=0010, the grant goes to requester 1 with ptr starting at 0.
REQ-040 SHALL cover code inputs while busy: code_i changed during a job -> the blink count is unaffected.
